pulse_push_counter: RTL and testbench

Top-level demo block for the CPLD board. A clock divider emits a periodic single-cycle strobe, a 4-bit counter counts those strobes, and a push-button detector counts debounced button presses into a second 4-bit register. Everything runs in one clock domain and drives board LEDs and debug pins.

---
 rtl/pulse_counter_pkg.sv | 22 ++
 rtl/pulse.sv | 30 +++
 rtl/push_sw.sv | 45 ++++
 rtl/ripple_carry_counter.sv | 23 ++
 rtl/sync_debounce.sv | 56 +++++
 rtl/pulse_push_counter.sv | 54 +++++
 tb/tb_pulse_push_counter.sv | 207 ++++++++++++++++++++
 7 files changed

// File: rtl/pulse_counter_pkg.sv
// Shared widths, default parameters and helpers for the pulse/push counter demo.
package pulse_counter_pkg;

  localparam int CNT_W               = 4;
  localparam int PULSE_DIV_DEF       = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PULSE_DIV_W         = $clog2(PULSE_DIV_DEF);
  localparam int DEBOUNCE_W          = $clog2(DEBOUNCE_CYCLES_DEF);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    LVL_RELEASED = 1'b0,
    LVL_PRESSED  = 1'b1
  } level_e;

  // A counter spanning 0..n-1 needs clog2(n) bits, but never fewer than one.
  function automatic int widthFor(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse.sv
// Clock divider producing a registered one-clock strobe every PULSE_DIV clocks.
module pulse
  import pulse_counter_pkg::*;
#(
  parameter int PULSE_DIV = PULSE_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_pulse
);

  localparam int            DIV_W = widthFor(PULSE_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(PULSE_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pulse;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse   <= (r_div_cnt == LAST);
      r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/push_sw.sv
// Push detector: conditions its input and counts rising edges of the resulting level.
// PUSH_LOOPBACK_EN bypasses the synchronizer/debouncer and edge-detects i_src directly.
module push_sw
  import pulse_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_src,
  output logic [CNT_W-1:0] o_push_reg
);

  logic w_level;
  logic r_prev;
  cnt_t r_push;

`ifdef PUSH_LOOPBACK_EN
  assign w_level = i_src;
`else
  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_din  (i_src),
    .o_level(w_level)
  );
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      r_push <= '0;
    end else begin
      r_prev <= w_level;
      if (w_level && !r_prev) begin
        r_push <= r_push + CNT_W'(1);
      end
    end
  end

  assign o_push_reg = r_push;

endmodule

// File: rtl/ripple_carry_counter.sv
// Synchronous modulo-16 counter advanced by an enable strobe in the i_clk domain.
module ripple_carry_counter
  import pulse_counter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  cnt_t r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a mismatch-counting debouncer; outputs the stable level.
module sync_debounce
  import pulse_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_level
);

  localparam int              DB_W = widthFor(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  level_e          r_stable;
  logic [DB_W-1:0] r_cnt;

  level_e          w_stable_nxt;
  logic [DB_W-1:0] w_cnt_nxt;
  logic            w_mismatch;
  logic            w_accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= LVL_RELEASED;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_din;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = '0;
    w_mismatch   = (r_sync2 != logic'(r_stable));
    w_accept     = w_mismatch && (r_cnt == LAST);
    if (w_accept) begin
      w_stable_nxt = level_e'(~logic'(r_stable));
    end else if (w_mismatch) begin
      w_cnt_nxt = r_cnt + DB_W'(1);
    end
  end

  // The accepting mismatch clock already presents the new level, so the level
  // changes on the clock the counter fills rather than one clock later.
  assign o_level = logic'(r_stable) ^ w_accept;

endmodule

// File: rtl/pulse_push_counter.sv
// CPLD demo top: divider strobe, strobe counter and debounced push-button counter.
// Define PUSH_LOOPBACK_EN to feed the push detector from the strobe instead of the button.
module pulse_push_counter
  import pulse_counter_pkg::*;
#(
  parameter int PULSE_DIV       = PULSE_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push_button,
  output logic             o_pulse,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_push_reg
);

  logic w_pulse;
  logic w_push_src;

`ifdef PUSH_LOOPBACK_EN
  logic w_unused_button;
  assign w_unused_button = i_push_button;
  assign w_push_src      = w_pulse;
`else
  assign w_push_src = i_push_button;
`endif

  pulse #(
    .PULSE_DIV(PULSE_DIV)
  ) u_pulse (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_pulse(w_pulse)
  );

  ripple_carry_counter u_ripple_carry_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_pulse),
    .o_count(o_count)
  );

  push_sw #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_push_sw (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_src     (w_push_src),
    .o_push_reg(o_push_reg)
  );

  assign o_pulse = w_pulse;

endmodule

// File: tb/tb_pulse_push_counter.sv
// Scoreboard bench for pulse_push_counter: an edge-indexed reference model queues the
// expected outputs each clock and a negedge monitor pops and compares them.
module tb_pulse_push_counter;

  localparam int PULSE_DIV       = 8;
  localparam int DEBOUNCE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pushButton = 1'b0;
  logic       pulseOut;
  logic [3:0] countOut;
  logic [3:0] pushOut;

  typedef struct {
    logic       pulse;
    logic [3:0] count;
    logic [3:0] push;
  } expect_t;

  expect_t expQ[$];
  expect_t monItem;
  int      checks = 0;
  int      errors = 0;

  int edgeK      = 0;
  bit btnHist[$];
  bit lvlHist[$];
  int pushModel  = 0;
  bit lastBtn    = 1'b0;
  bit inReset    = 1'b1;

  pulse_push_counter #(
    .PULSE_DIV      (PULSE_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_push_button(pushButton),
    .o_pulse      (pulseOut),
    .o_count      (countOut),
    .o_push_reg   (pushOut)
  );

  always #5 clk = ~clk;

  // Edge k counts rising edges since reset release; the model is written in those terms.
  function automatic int expCount();
    return (edgeK >= 1) ? ((edgeK - 1) / PULSE_DIV) % 16 : 0;
  endfunction

  function automatic bit expPulse();
    return (edgeK > 0) && (edgeK % PULSE_DIV == 0);
  endfunction

  // Button value seen at the synchronizer output after edge j (two-clock delay).
  function automatic bit syncAfter(input int j);
    if (j < 2) return 1'b0;
    return btnHist[j-1];
  endfunction

  task automatic modelReset();
    edgeK = 0;
    btnHist.delete();
    lvlHist.delete();
    btnHist.push_back(1'b0);
    lvlHist.push_back(1'b0);
    pushModel = 0;
  endtask

  // The debounced level flips once the last DEBOUNCE_CYCLES synchronized samples all
  // disagree with it; a press is counted one clock after the level rises.
  task automatic modelEdge();
    bit prevLvl;
    bit allOpp;
    bit newLvl;
    edgeK++;
    btnHist.push_back(lastBtn);
    prevLvl = lvlHist[edgeK-1];
    allOpp  = 1'b1;
    for (int i = 0; i < DEBOUNCE_CYCLES; i++) begin
      if (syncAfter(edgeK - i) == prevLvl) allOpp = 1'b0;
    end
    newLvl = allOpp ? ~prevLvl : prevLvl;
    lvlHist.push_back(newLvl);
    if (edgeK >= 2 && lvlHist[edgeK-1] && !lvlHist[edgeK-2]) begin
      pushModel = (pushModel + 1) % 16;
    end
  endtask

  task automatic pushExpected();
    expect_t e;
    e.pulse = expPulse();
    e.count = 4'(expCount());
`ifdef PUSH_LOOPBACK_EN
    e.push  = 4'(expCount());
`else
    e.push  = 4'(pushModel);
`endif
    expQ.push_back(e);
  endtask

  // One clock of stimulus: the edge just taken is folded into the model, then the new
  // reset/button levels are driven (reset asserts asynchronously here, between edges).
  task automatic applyStimulus(input bit r, input bit b);
    @(posedge clk);
    #2;
    if (!inReset) modelEdge();
    rst        = r;
    pushButton = b;
    lastBtn    = b;
    inReset    = r;
    if (r) modelReset();
    pushExpected();
  endtask

  task automatic checkOutput(input expect_t e);
    checks += 3;
    if (pulseOut !== e.pulse) begin
      errors++;
      $display("[TB] FAIL pulse at %0t got %0b want %0b", $time, pulseOut, e.pulse);
    end
    if (countOut !== e.count) begin
      errors++;
      $display("[TB] FAIL count at %0t got %0d want %0d", $time, countOut, e.count);
    end
    if (pushOut !== e.push) begin
      errors++;
      $display("[TB] FAIL push_reg at %0t got %0d want %0d", $time, pushOut, e.push);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monItem = expQ.pop_front();
      checkOutput(monItem);
    end
  end

  initial begin
    int guard;
    int runLen;
    bit lvl;
    modelReset();

    $display("[TB] reset release and wrap");
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (140) applyStimulus(1'b0, 1'b0);

    $display("[TB] clean press and release");
    repeat (20) applyStimulus(1'b0, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b0);

    $display("[TB] glitch rejection");
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0);

    $display("[TB] bounce then hold");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'(i % 2 == 0));
    repeat (15) applyStimulus(1'b0, 1'b1);
    repeat (15) applyStimulus(1'b0, 1'b0);

    $display("[TB] reset mid-count");
    guard = 0;
    while (expCount() != 5 && guard < 400) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (expCount() != 5) begin
      errors++;
      $display("[TB] FAIL reach_count5 got %0d want 5", expCount());
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0);

    $display("[TB] button held through reset");
    applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0);

    $display("[TB] random button runs");
    lvl = 1'b0;
    for (int n = 0; n < 150; n++) begin
      lvl    = ~lvl;
      runLen = $urandom_range(1, 8);
      for (int c = 0; c < runLen; c++) begin
        if ($urandom_range(0, 299) == 0) applyStimulus(1'b1, lvl);
        else applyStimulus(1'b0, lvl);
      end
    end
    repeat (10) applyStimulus(1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
